// File: rtl/cix32_prefetch_queue_pkg.sv
// cix32_pfq_pkg: shared types and helpers for the CIX-32 instruction
// prefetch queue.
//   pfq_state_t : fetch FSM encoding (IDLE / REQ / DROP)
//   WORD_BYTES  : bytes per memory bus word
//   fill_count  : number of bytes a fill enqueues for a given address offset
package cix32_pfq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } pfq_state_t;

  localparam int WORD_BYTES = 4;

  // An unaligned fetch only enqueues the bytes from its offset to the end of the word.
  function automatic logic [2:0] fill_count(input logic [1:0] offset);
    return 3'(WORD_BYTES) - {1'b0, offset};
  endfunction

endpackage

// File: rtl/cix32_prefetch_queue_if.sv
// cix32_prefetch_queue_if: core-side and memory-side handshakes of the
// prefetch queue.
//   core_addr/core_req            : core byte fetch request
//   core_rdata/core_ready/core_avail : bytes served back to the core
//   mem_addr/mem_req              : word fetch to instruction memory
//   mem_rdata/mem_ready           : memory read response
// modport master: the prefetch queue (bus master towards memory).
// modport slave : the environment (core + memory).
interface cix32_prefetch_queue_if;
  logic [31:0] core_addr;
  logic        core_req;
  logic [31:0] core_rdata;
  logic        core_ready;
  logic [2:0]  core_avail;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  core_addr, core_req, mem_rdata, mem_ready,
    output core_rdata, core_ready, core_avail, mem_addr, mem_req
  );

  modport slave (
    output core_addr, core_req, mem_rdata, mem_ready,
    input  core_rdata, core_ready, core_avail, mem_addr, mem_req
  );
endinterface

// File: rtl/cix32_prefetch_queue_byte_ram.sv
// cix32_pfq_byte_ram: circular byte storage for the prefetch queue.
//   clk      : clock
//   we_i     : write enable
//   wptr_i   : byte slot for write lane 0; lane i goes to wptr_i+i (wraps)
//   wmask_i  : per-lane write mask
//   wdata_i  : lane data, lane 0 in [7:0]
//   rptr_i   : byte slot read into rdata_o[7:0]; following slots above it
//   rdata_o  : four consecutive bytes starting at rptr_i
module cix32_pfq_byte_ram
  import cix32_pfq_pkg::*;
#(
  parameter int DEPTH_BYTES = 16,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wptr_i,
  input  logic [3:0]    wmask_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] rptr_i,
  output logic [31:0]   rdata_o
);

  logic [7:0] mem_q [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wmask_i[i]) mem_q[wptr_i + AW'(i)] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rdata_o[8*i +: 8] = mem_q[rptr_i + AW'(i)];
    end
  end

endmodule

// File: rtl/cix32_prefetch_queue.sv
// cix32_prefetch_queue: instruction prefetch queue for the CIX-32 core.
// Fetches aligned words ahead of the core into a circular byte buffer and
// serves bytes at the queue head. A core request at any other address
// flushes the queue and refetches from there.
//   clk, rst : clock, synchronous active-high reset
//   bus      : core and memory handshakes (cix32_prefetch_queue_if.master)
//   stat_redirects, stat_words : only with CIX32_PFQ_STATS_EN defined;
//              wrapping counts of redirects and of fills kept in the queue.
//
// state | meaning
// IDLE  | no request; waiting for at least one word of free space
// REQ   | mem_req high at the current fetch address
// DROP  | redirected mid-request; finish the stale request and discard it
module cix32_prefetch_queue
  import cix32_pfq_pkg::*;
#(
  parameter int          DEPTH_BYTES = 16,
  parameter logic [31:0] RESET_ADDR  = 32'h000FFFF0
) (
  input  logic clk,
  input  logic rst,
  cix32_prefetch_queue_if.master bus
`ifdef CIX32_PFQ_STATS_EN
  ,
  output logic [15:0] stat_redirects,
  output logic [31:0] stat_words
`endif
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;

  pfq_state_t  state_q, state_d;
  logic [31:0] head_q, head_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] stale_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;

  logic        match, redirect, consume, fill;
  logic [2:0]  n, avail;
  logic [CW-1:0] space_q, space_d;
  logic [31:0] ram_rdata;

  always_comb begin
    match    = (bus.core_addr == head_q);
    redirect = bus.core_req && !match;
    consume  = bus.core_req && match && (count_q != '0);
    n        = fill_count(fetch_q[1:0]);
    fill     = (state_q == REQ) && bus.mem_ready && !redirect;
    space_q  = CW'(DEPTH_BYTES) - count_q;

    head_d  = head_q;
    fetch_d = fetch_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (redirect) begin
      head_d  = bus.core_addr;
      fetch_d = bus.core_addr;
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (consume) begin
        head_d = head_q + 32'd1;
        rptr_d = rptr_q + AW'(1);
      end
      if (fill) begin
        fetch_d = fetch_q + 32'(n);
        wptr_d  = wptr_q + AW'(n);
      end
      count_d = count_q + (fill ? CW'(n) : '0) - (consume ? CW'(1) : '0);
    end
    space_d = CW'(DEPTH_BYTES) - count_d;

    state_d = state_q;
    unique case (state_q)
      // A redirect empties the queue, so fetching can start right away.
      IDLE: if (redirect || space_q >= CW'(WORD_BYTES)) state_d = REQ;
      REQ: begin
        if (redirect)           state_d = bus.mem_ready ? REQ : DROP;
        else if (bus.mem_ready) state_d = (space_d >= CW'(WORD_BYTES)) ? REQ : IDLE;
      end
      DROP: if (bus.mem_ready) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= RESET_ADDR;
      fetch_q <= RESET_ADDR;
      stale_q <= {RESET_ADDR[31:2], 2'b00};
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      fetch_q <= fetch_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      // Freeze the outstanding address while a discarded request drains.
      if (state_q != DROP) stale_q <= bus.mem_addr;
    end
  end

  cix32_pfq_byte_ram #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
    .clk     (clk),
    .we_i    (fill),
    .wptr_i  (wptr_q),
    .wmask_i (4'b1111 >> fetch_q[1:0]),
    .wdata_i (bus.mem_rdata >> {fetch_q[1:0], 3'b000}),
    .rptr_i  (rptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    if (!match)                             avail = 3'd0;
    else if (count_q >= CW'(WORD_BYTES))    avail = 3'd4;
    else                                    avail = count_q[2:0];

    bus.core_rdata = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (3'(i) < avail) bus.core_rdata[8*i +: 8] = ram_rdata[8*i +: 8];
    end
    bus.core_avail = avail;
    bus.core_ready = match && (count_q != '0);
    bus.mem_addr   = (state_q == DROP) ? stale_q : {fetch_q[31:2], 2'b00};
    // Reset abandons an outstanding request in the same cycle.
    bus.mem_req    = (state_q != IDLE) && !rst;
  end

`ifdef CIX32_PFQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_redirects <= '0;
      stat_words     <= '0;
    end else begin
      if (redirect) stat_redirects <= stat_redirects + 16'd1;
      if (fill)     stat_words     <= stat_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cix32_prefetch_queue.sv
// Directed bench for cix32_prefetch_queue. Memory byte at address a holds
// a[7:0]^8'hB8 (so 32'h000FFFF0 reads 32'h4B4A4948).
module tb_cix32_prefetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   fills;

`ifdef CIX32_PFQ_STATS_EN
  logic [15:0] stat_redirects;
  logic [31:0] stat_words;
`endif

  cix32_prefetch_queue_if bus ();

  cix32_prefetch_queue #(.DEPTH_BYTES(16), .RESET_ADDR(32'h000FFFF0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CIX32_PFQ_STATS_EN
    ,
    .stat_redirects (stat_redirects),
    .stat_words     (stat_words)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ 8'hB8;
  endfunction

  always_comb begin
    bus.mem_rdata = {mem_byte(bus.mem_addr + 32'd3), mem_byte(bus.mem_addr + 32'd2),
                     mem_byte(bus.mem_addr + 32'd1), mem_byte(bus.mem_addr)};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.core_addr = 32'h000FFFF0;
    bus.core_req  = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    check("rst_core_ready", 32'(bus.core_ready), 32'd0);
    check("rst_core_avail", 32'(bus.core_avail), 32'd0);
    check("rst_core_rdata", bus.core_rdata, 32'h0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h000FFFF0);

    // First fetch after reset release
    rst = 1'b0;
    #1;
    check("idle_mem_req", 32'(bus.mem_req), 32'd0);
    tick();
    check("first_mem_req", 32'(bus.mem_req), 32'd1);
    check("first_mem_addr", bus.mem_addr, 32'h000FFFF0);
    check("first_not_ready", 32'(bus.core_ready), 32'd0);
    tick();
    check("first_ready", 32'(bus.core_ready), 32'd1);
    check("first_rdata", bus.core_rdata, 32'h4B4A4948);
    check("first_avail", 32'(bus.core_avail), 32'd4);

    // Sequential byte reads 48,49,4A,4B
    bus.core_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.core_addr = 32'h000FFFF0 + 32'(k);
      #1;
      check("seq_byte", 32'(bus.core_rdata[7:0]), 32'h48 + 32'(k));
      tick();
    end
    bus.core_req = 1'b0;
    #1;
    check("seq_count12", 32'(dut.count_q), 32'd12);
    check("seq_idle", 32'(bus.mem_req), 32'd0);
    tick();
    check("refill_req", 32'(bus.mem_req), 32'd1);
    check("refill_addr", bus.mem_addr, 32'h00100000);

    // Fill and consume together at count 12
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h000FFFF4;
    #1;
    check("byte_fff4", 32'(bus.core_rdata[7:0]), 32'h4C);
    tick();
    bus.core_req = 1'b0;
    #1;
    check("fill_consume_count", 32'(dut.count_q), 32'd15);
    check("fill_consume_idle", 32'(bus.mem_req), 32'd0);

    // Redirect to 0x2000, then stall the core: exactly four fills
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h00002000;
    #1;
    check("mismatch_ready", 32'(bus.core_ready), 32'd0);
    check("mismatch_avail", 32'(bus.core_avail), 32'd0);
    tick();
    bus.core_req = 1'b0;
    #1;
    check("redir_mem_addr", bus.mem_addr, 32'h00002000);
    fills = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.mem_req) fills++;
      tick();
    end
    check("stall_fills", 32'(fills), 32'd4);
    check("stall_count16", 32'(dut.count_q), 32'd16);
    check("stall_no_req", 32'(bus.mem_req), 32'd0);
    check("stall_rdata", bus.core_rdata, 32'hBBBAB9B8);

    bus.core_req = 1'b1;
    tick();
    bus.core_req  = 1'b0;
    bus.core_addr = 32'h00002001;
    tick();
    tick();
    check("one_consume_no_req", 32'(bus.mem_req), 32'd0);
    check("one_consume_count", 32'(dut.count_q), 32'd15);
    bus.core_req = 1'b1;
    for (int k = 1; k < 4; k++) begin
      bus.core_addr = 32'h00002000 + 32'(k);
      tick();
    end
    bus.core_req = 1'b0;
    #1;
    check("four_consume_still_idle", 32'(bus.mem_req), 32'd0);
    tick();
    check("four_consume_req", 32'(bus.mem_req), 32'd1);
    check("four_consume_addr", bus.mem_addr, 32'h00002010);
    tick();

    // Unaligned redirect: only lane 3 of the first word
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h00001003;
    tick();
    bus.core_req = 1'b0;
    #1;
    check("unal_mem_addr", bus.mem_addr, 32'h00001000);
    check("unal_mem_req", 32'(bus.mem_req), 32'd1);
    tick();
    check("unal_avail", 32'(bus.core_avail), 32'd1);
    check("unal_rdata", bus.core_rdata, 32'h000000BB);
    check("unal_next_addr", bus.mem_addr, 32'h00001004);
    tick();
    check("unal_avail4", 32'(bus.core_avail), 32'd4);
    check("unal_rdata4", bus.core_rdata, 32'hBEBDBCBB);

    // Redirect while memory stalls
    bus.mem_ready = 1'b0;
    tick();
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h00003000;
    tick();
    bus.core_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drop_mem_req", 32'(bus.mem_req), 32'd1);
      check("drop_mem_addr", bus.mem_addr, 32'h00001008);
      check("drop_not_ready", 32'(bus.core_ready), 32'd0);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("drop_stale_rdata", bus.core_rdata, 32'h0);
    tick();
    check("drop_new_addr", bus.mem_addr, 32'h00003000);
    check("drop_new_req", 32'(bus.mem_req), 32'd1);
    check("drop_discarded", 32'(bus.core_avail), 32'd0);
    tick();
    check("drop_new_rdata", bus.core_rdata, 32'hBBBAB9B8);
    check("drop_new_avail", 32'(bus.core_avail), 32'd4);

    // Address wrap past 32'hFFFFFFFC, redirect-to-data latency 2
    bus.core_req  = 1'b1;
    bus.core_addr = 32'hFFFFFFFC;
    tick();
    bus.core_req = 1'b0;
    #1;
    check("wrap_mem_addr", bus.mem_addr, 32'hFFFFFFFC);
    check("wrap_not_ready", 32'(bus.core_ready), 32'd0);
    tick();
    check("wrap_ready", 32'(bus.core_ready), 32'd1);
    check("wrap_rdata", bus.core_rdata, 32'h47464544);
    check("wrap_next_addr", bus.mem_addr, 32'h00000000);

`ifdef CIX32_PFQ_STATS_EN
    check("stat_redirects", 32'(stat_redirects), 32'd4);
    check("stat_words", stat_words, 32'd14);
`endif

    // Reset mid-request
    rst = 1'b1;
    #1;
    check("rst_drops_req", 32'(bus.mem_req), 32'd0);
    tick();
    check("rst2_ready", 32'(bus.core_ready), 32'd0);
    check("rst2_mem_addr", bus.mem_addr, 32'h000FFFF0);
`ifdef CIX32_PFQ_STATS_EN
    check("rst_stat_words", stat_words, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
